// File: rtl/dct_pkg.sv
// Shared constants, bank-state and FSM encodings for the DCT-to-IDCT
// coefficient requantisation buffer.
package dct_pkg;

  localparam int DW       = 32;
  localparam int CW       = 14;
  localparam int NCOEF    = 64;
  localparam int MAXSH    = 7;
  localparam int SW       = $clog2(MAXSH + 1);
  localparam int AW       = $clog2(NCOEF);
  localparam int COEF_MSB = 31;
  localparam int COEF_LSB = 18;

  localparam logic [AW-1:0] LAST_IDX = AW'(NCOEF - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;
  typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} r_state_e;

  function automatic logic [DW-1:0] sext_coef(input logic [CW-1:0] v);
    return {{(DW - CW){v[CW-1]}}, v};
  endfunction

endpackage

// File: rtl/coef_requant_buffer_if.sv
// Write-side (DCT) and read-side (IDCT) stream signals of the requant buffer.
interface coef_requant_buffer_if;

  logic                    in_valid;
  logic [dct_pkg::DW-1:0]  din;
  logic [dct_pkg::SW-1:0]  qshift;
  logic                    in_full;
  logic                    overflow;
  logic                    out_start;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic [dct_pkg::DW-1:0]  dout;

  modport slave (
    input  in_valid, din, qshift, out_ready,
    output in_full, overflow, out_start, out_valid, out_last, dout
  );

  modport master (
    output in_valid, din, qshift, out_ready,
    input  in_full, overflow, out_start, out_valid, out_last, dout
  );

endinterface

// File: rtl/coef_quant.sv
// Quantise/dequantise one coefficient: shift by s with round-half-away-from-zero,
// scale back up and saturate to the signed CW-bit range.
module coef_quant
  import dct_pkg::*;
(
  input  logic [CW-1:0] c,
  input  logic [SW-1:0] s,
  output logic [CW-1:0] v
);

  localparam logic signed [CW+1:0] SAT_MAX = 16'sd8191;
  localparam logic signed [CW+1:0] SAT_MIN = -16'sd8192;

  logic [CW+1:0] c_ext_s;
  logic [CW+1:0] mag_s;
  logic [CW+1:0] rnd_s;
  logic [CW+1:0] m_s;
  logic [CW+1:0] q_s;
  logic [CW+1:0] sv_s;

  // Two guard bits keep |c| + half-step and its rescaled value exact before saturation.
  always_comb begin
    c_ext_s = {{2{c[CW-1]}}, c};
    if (c[CW-1]) begin
      mag_s = 16'd0 - c_ext_s;
    end else begin
      mag_s = c_ext_s;
    end
    if (s == 3'd0) begin
      rnd_s = 16'd0;
    end else begin
      rnd_s = 16'd1 << (s - 3'd1);
    end
    m_s = (mag_s + rnd_s) >> s;
    q_s = m_s << s;
    if (c[CW-1]) begin
      sv_s = 16'd0 - q_s;
    end else begin
      sv_s = q_s;
    end
    if ($signed(sv_s) > SAT_MAX) begin
      v = 14'h1FFF;
    end else if ($signed(sv_s) < SAT_MIN) begin
      v = 14'h2000;
    end else begin
      v = sv_s[CW-1:0];
    end
  end

endmodule

// File: rtl/coef_requant_buffer.sv
// Captures 64-coefficient DCT blocks, requantises each coefficient and replays
// them to the IDCT from a ping-pong buffer under valid/ready.
module coef_requant_buffer
  import dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  coef_requant_buffer_if.slave bus
);

  logic [CW-1:0] mem_r [2][NCOEF];
  bank_state_e   bank_r [2];
  bank_state_e   bank_next_s [2];

  w_state_e      w_state_r, w_state_next_s;
  r_state_e      r_state_r, r_state_next_s;
  logic [AW-1:0] wcnt_r, wcnt_next_s, wr_addr_s;
  logic [AW-1:0] rcnt_r, rcnt_next_s, rd_idx_s;
  logic          wr_bank_r, wr_bank_next_s, rd_bank_r, rd_bank_next_s, rd_sel_s;
  logic [SW-1:0] qsh_r, qsh_next_s, shift_s;
  logic          wr_en_s, wr_done_s, ovf_set_s, wr_bank_free_s, rd_free_s, load_s;
  logic          out_valid_r, out_valid_next_s;
  logic          out_start_r, out_start_next_s;
  logic          out_last_r, out_last_next_s;
  logic          in_full_r, overflow_r;
  logic [DW-1:0] dout_r;
  logic [CW-1:0] v_s;

  coef_quant u_quant (
    .c (bus.din[COEF_MSB:COEF_LSB]),
    .s (shift_s),
    .v (v_s)
  );

  // A bank being released by the reader this cycle may already take word 0.
  assign wr_bank_free_s = (bank_r[wr_bank_r] == EMPTY) ||
                          (rd_free_s && (rd_bank_r == wr_bank_r));

  // Write FSM next state; word 0 uses the live qshift, later words the latched one.
  always_comb begin
    w_state_next_s = w_state_r;
    wcnt_next_s    = wcnt_r;
    wr_bank_next_s = wr_bank_r;
    qsh_next_s     = qsh_r;
    shift_s        = qsh_r;
    wr_addr_s      = wcnt_r;
    wr_en_s        = 1'b0;
    wr_done_s      = 1'b0;
    ovf_set_s      = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        shift_s   = bus.qshift;
        wr_addr_s = {AW{1'b0}};
        if (bus.in_valid && wr_bank_free_s) begin
          wr_en_s        = 1'b1;
          qsh_next_s     = bus.qshift;
          wcnt_next_s    = 6'd1;
          w_state_next_s = W_FILL;
        end else if (bus.in_valid) begin
          ovf_set_s = 1'b1;
        end else begin
          ovf_set_s = 1'b0;
        end
      end
      W_FILL: begin
        if (bus.in_valid) begin
          wr_en_s = 1'b1;
          if (wcnt_r == LAST_IDX) begin
            wr_done_s      = 1'b1;
            wcnt_next_s    = {AW{1'b0}};
            wr_bank_next_s = ~wr_bank_r;
            w_state_next_s = W_IDLE;
          end else begin
            wcnt_next_s = wcnt_r + 6'd1;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: w_state_next_s = W_IDLE;
    endcase
  end

  // Read FSM next state; dout is prefetched so the next word is ready on acceptance.
  always_comb begin
    r_state_next_s   = r_state_r;
    rcnt_next_s      = rcnt_r;
    rd_bank_next_s   = rd_bank_r;
    rd_free_s        = 1'b0;
    load_s           = 1'b0;
    rd_sel_s         = rd_bank_r;
    rd_idx_s         = rcnt_r;
    out_valid_next_s = out_valid_r;
    out_start_next_s = out_start_r;
    out_last_next_s  = out_last_r;
    case (r_state_r)
      R_IDLE: begin
        if (bank_r[rd_bank_r] == FULL) begin
          r_state_next_s   = R_DRAIN;
          rcnt_next_s      = {AW{1'b0}};
          rd_idx_s         = {AW{1'b0}};
          load_s           = 1'b1;
          out_valid_next_s = 1'b1;
          out_start_next_s = 1'b1;
          out_last_next_s  = 1'b0;
        end else begin
          load_s = 1'b0;
        end
      end
      R_DRAIN: begin
        if (out_valid_r && bus.out_ready && (rcnt_r == LAST_IDX)) begin
          rd_free_s      = 1'b1;
          rd_bank_next_s = ~rd_bank_r;
          if (bank_r[~rd_bank_r] == FULL) begin
            rcnt_next_s     = {AW{1'b0}};
            rd_sel_s        = ~rd_bank_r;
            rd_idx_s        = {AW{1'b0}};
            load_s          = 1'b1;
            out_last_next_s = 1'b0;
          end else begin
            r_state_next_s   = R_IDLE;
            out_valid_next_s = 1'b0;
            out_start_next_s = 1'b0;
            out_last_next_s  = 1'b0;
          end
        end else if (out_valid_r && bus.out_ready) begin
          rcnt_next_s     = rcnt_r + 6'd1;
          rd_idx_s        = rcnt_r + 6'd1;
          load_s          = 1'b1;
          out_last_next_s = ((rcnt_r + 6'd1) == LAST_IDX);
        end else begin
          load_s = 1'b0;
        end
      end
      default: r_state_next_s = R_IDLE;
    endcase
  end

  // Bank occupancy: the reader and writer never target the same bank in one cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (rd_free_s && (int'(rd_bank_r) == i)) begin
        bank_next_s[i] = EMPTY;
      end else if (wr_done_s && (int'(wr_bank_r) == i)) begin
        bank_next_s[i] = FULL;
      end else begin
        bank_next_s[i] = bank_r[i];
      end
    end
  end

  // Coefficient storage; contents are only meaningful for banks marked FULL.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_bank_r][wr_addr_s] <= v_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_r   <= W_IDLE;
      r_state_r   <= R_IDLE;
      wcnt_r      <= {AW{1'b0}};
      rcnt_r      <= {AW{1'b0}};
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      qsh_r       <= {SW{1'b0}};
      bank_r[0]   <= EMPTY;
      bank_r[1]   <= EMPTY;
      out_valid_r <= 1'b0;
      out_start_r <= 1'b0;
      out_last_r  <= 1'b0;
      in_full_r   <= 1'b0;
      overflow_r  <= 1'b0;
      dout_r      <= {DW{1'b0}};
    end else begin
      w_state_r   <= w_state_next_s;
      r_state_r   <= r_state_next_s;
      wcnt_r      <= wcnt_next_s;
      rcnt_r      <= rcnt_next_s;
      wr_bank_r   <= wr_bank_next_s;
      rd_bank_r   <= rd_bank_next_s;
      qsh_r       <= qsh_next_s;
      bank_r      <= bank_next_s;
      out_valid_r <= out_valid_next_s;
      out_start_r <= out_start_next_s;
      out_last_r  <= out_last_next_s;
      in_full_r   <= (bank_next_s[0] == FULL) && (bank_next_s[1] == FULL);
      overflow_r  <= overflow_r | ovf_set_s;
      if (load_s) begin
        dout_r <= sext_coef(mem_r[rd_sel_s][rd_idx_s]);
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_start = out_start_r;
  assign bus.out_last  = out_last_r;
  assign bus.dout      = dout_r;
  assign bus.in_full   = in_full_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_coef_requant_buffer.sv
// Scoreboard bench for coef_requant_buffer: random blocks go through an
// arithmetic reference model; a monitor pops and compares every accepted word.
module tb_coef_requant_buffer;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic clk;
  logic reset;
  coef_requant_buffer_if bus ();

  coef_requant_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb_q[$];
  int   blk_c[64];
  int   n_chk, n_pass;
  int   blocks_sent, blocks_done, words_out, words_before;
  int   ready_mode;
  bit   mon_resync;
  time  t_last_edge, t_blk_start, t_blk_end;
  int   span;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_q(input int c, input int s);
    int m, v, a;
    a = (c < 0) ? -c : c;
    if (s == 0) begin
      v = c;
    end else begin
      m = (a + (1 << (s - 1))) >> s;
      v = (c < 0) ? -(m << s) : (m << s);
    end
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endtask

  task automatic rand_block();
    for (int i = 0; i < 64; i++) blk_c[i] = int'($urandom_range(0, 16383)) - 8192;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last word's edge.
  task automatic send_block(input int s, input bit gaps, input bit expect_ok, input int nwords);
    int   guard;
    exp_t e;
    if (expect_ok) begin
      guard = 0;
      while ((blocks_sent - blocks_done) >= 2 && guard < 3000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 3000) fail_now("room_wait_timeout", 32'(blocks_sent - blocks_done));
    end
    for (int i = 0; i < nwords; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.din      = {14'(blk_c[i]), 18'($urandom)};
      bus.qshift   = (i == 0) ? 3'(s) : 3'($urandom);
      if (i == 63 && expect_ok) begin
        for (int j = 0; j < 64; j++) begin
          e.d = 32'(ref_q(blk_c[j], s));
          e.l = (j == 63);
          sb_q.push_back(e);
        end
      end
      @(posedge clk);
      t_last_edge = $time;
      #1;
    end
    bus.in_valid = 1'b0;
    if (expect_ok && nwords == 64) blocks_sent++;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || bus.out_valid !== 1'b0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) fail_now("drain_timeout", 32'(sb_q.size()));
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        2:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom);
      endcase
    end
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] held;
    bit          pending, new_blk;
    pending = 1'b0;
    new_blk = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_resync) begin
        new_blk    = 1'b1;
        pending    = 1'b0;
        mon_resync = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
        if (new_blk) begin
          t_blk_start = $time;
          new_blk     = 1'b0;
        end
        chk("out_start", 32'(bus.out_start), 32'd1);
        if (pending) chk("hold_dout", bus.dout, held);
        if (bus.out_ready === 1'b1) begin
          words_out++;
          if (sb_q.size() == 0) begin
            fail_now("unexpected_word", bus.dout);
          end else begin
            e = sb_q.pop_front();
            chk("dout", bus.dout, e.d);
            chk("out_last", 32'(bus.out_last), 32'(e.l));
            if (e.l) begin
              blocks_done++;
              t_blk_end = $time;
              new_blk   = 1'b1;
            end
          end
          pending = 1'b0;
        end else begin
          pending = 1'b1;
          held    = bus.dout;
        end
      end else begin
        pending = 1'b0;
      end
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    blocks_sent = 0; blocks_done = 0; words_out = 0;
    ready_mode = 1; mon_resync = 1'b0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.din = 32'd0; bus.qshift = 3'd0; bus.out_ready = 1'b0;
    fork
      ready_drv();
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_start", 32'(bus.out_start), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_in_full",   32'(bus.in_full),   32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_dout",      bus.dout,           32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: identity shift, ramp 0..63, latency and span
    for (int i = 0; i < 64; i++) blk_c[i] = i;
    send_block(0, 1'b0, 1'b1, 64);
    wait_drain();
    chk("t1_latency", 32'(t_blk_start - t_last_edge), 32'd15);
    chk("t1_span", 32'((t_blk_end - t_blk_start) / 10 + 1), 32'd64);
    chk("t1_start_low", 32'(bus.out_start), 32'd0);

    // 2 and 3: rounding and saturation corners, with input gaps
    rand_block();
    blk_c[0] = 13; blk_c[1] = -13; blk_c[2] = 4; blk_c[3] = -4; blk_c[4] = 3;
    send_block(3, 1'b1, 1'b1, 64);
    rand_block();
    blk_c[0] = 8191; blk_c[1] = -8192; blk_c[2] = -64; blk_c[3] = 64; blk_c[4] = -8191;
    send_block(7, 1'b1, 1'b1, 64);
    wait_drain();

    // Random blocks against a randomly stalling consumer
    ready_mode = 3;
    for (int b = 0; b < 4; b++) begin
      rand_block();
      send_block(int'($urandom_range(0, 7)), 1'b1, 1'b1, 64);
    end
    wait_drain();

    // 5: alternating ready
    ready_mode = 2;
    rand_block();
    send_block(int'($urandom_range(0, 7)), 1'b0, 1'b1, 64);
    wait_drain();
    span = int'((t_blk_end - t_blk_start) / 10 + 1);
    chk("t5_span", 32'(span >= 127 && span <= 128), 32'd1);

    // 4: both banks full, third block dropped
    ready_mode = 0;
    @(posedge clk); #1;
    rand_block();
    send_block(int'($urandom_range(0, 7)), 1'b0, 1'b1, 64);
    rand_block();
    send_block(int'($urandom_range(0, 7)), 1'b0, 1'b1, 64);
    chk("t4_in_full", 32'(bus.in_full), 32'd1);
    chk("t4_no_ovf_yet", 32'(bus.overflow), 32'd0);
    rand_block();
    send_block(int'($urandom_range(0, 7)), 1'b0, 1'b0, 64);
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    chk("t4_in_full_hold", 32'(bus.in_full), 32'd1);
    chk("t4_pending", 32'(sb_q.size()), 32'd128);
    words_before = words_out;
    ready_mode = 1;
    wait_drain();
    chk("t4_words", 32'(words_out - words_before), 32'd128);
    chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("t4_in_full_clr", 32'(bus.in_full), 32'd0);

    // 6: reset mid-block discards everything
    ready_mode = 0;
    @(posedge clk); #1;
    rand_block();
    blk_c[0] = 100;
    send_block(0, 1'b0, 1'b1, 64);
    rand_block();
    send_block(2, 1'b0, 1'b0, 30);
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_pre_dout", bus.dout, 32'd100);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_start", 32'(bus.out_start), 32'd0);
    chk("t6_rst_last",  32'(bus.out_last),  32'd0);
    chk("t6_rst_dout",  bus.dout,           32'd0);
    chk("t6_rst_ovf",   32'(bus.overflow),  32'd0);
    chk("t6_rst_full",  32'(bus.in_full),   32'd0);
    sb_q.delete();
    blocks_sent = 0;
    blocks_done = 0;
    mon_resync  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b1;
    ready_mode = 1;
    @(posedge clk); #1;
    rand_block();
    send_block(int'($urandom_range(0, 7)), 1'b1, 1'b1, 64);
    wait_drain();
    chk("t6_blocks_done", 32'(blocks_done), 32'd1);
    chk("t6_ovf_clear", 32'(bus.overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/coef_requant_buffer.md
Name: coef_requant_buffer

Overview:
Sits between the forward DCT and the IDCT in the approximate DCT/IDCT datapath, and replaces the plain bit-slice glue between them.
- Captures each 64-coefficient block the DCT streams out on `done`.
- Extracts the 14-bit coefficient field `din[31:18]` and applies a runtime quantise/dequantise (arithmetic shift with symmetric rounding and saturation).
- Stores the block in a ping-pong buffer and replays it to the IDCT under a valid/ready handshake, so DCT output and IDCT input are decoupled.

Parameters:
- DW, 32, width of input and output data words
- CW, 14, coefficient field width taken from the top of `din`
- NCOEF, 64, coefficients per block
- MAXSH, 7, largest legal quantiser shift

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  DCT `done`; one coefficient per cycle while high
- din  in  32  DCT output word; coefficient is `din[31:18]`
- qshift  in  3  quantiser shift s; sampled at the first word of each block
- out_start  out  1  IDCT `start`; high from first to last word of a block
- out_valid  out  1  `dout` holds a valid coefficient
- out_ready  in  1  IDCT accepts `dout` this cycle
- dout  out  32  dequantised coefficient, sign-extended to 32 bits
- out_last  out  1  high with the 64th word of a block
- in_full  out  1  both banks full; the next `in_valid` word is dropped
- overflow  out  1  sticky flag; cleared only by reset

Behaviour:
Reset (`reset` = 0, asynchronous):
- Both banks EMPTY; write and read counters = 0; `wr_bank` = `rd_bank` = 0.
- Outputs: `out_start`=0, `out_valid`=0, `out_last`=0, `in_full`=0, `overflow`=0, `dout`=0.
- Reset mid-block discards all buffered data. There is no partial-block flush.

Arithmetic (combinational on the write side, registered into the bank):
- c = signed `din[31:18]`; s = block's latched `qshift`.
- If s=0: v=c.
- Otherwise: m = (|c| + 2^(s-1)) >> s, then v = sign(c) * (m << s).
- Saturate v to [-8192, 8191].
- Bank stores the 14-bit v. `dout` = {18 copies of v[13], v}.

Write FSM (states W_IDLE, W_FILL):
- W_IDLE: on `in_valid` with `wr_bank` EMPTY, write word 0, latch `qshift`, go to W_FILL with `wcnt`=1.
- W_FILL: each `in_valid` cycle writes `wcnt` and increments it.
- If `in_valid` drops before 64 words, hold `wcnt` and resume on the next high. There is no timeout.
- On the write of word 63: mark bank FULL, toggle `wr_bank`, go to W_IDLE.
- If `in_valid` arrives while `wr_bank` is not EMPTY: drop the word, set `overflow`, stay in W_IDLE.
- `in_full` = (bank0 != EMPTY) && (bank1 != EMPTY), registered.

Read FSM (states R_IDLE, R_DRAIN):
- R_IDLE: when `rd_bank` is FULL, go to R_DRAIN next cycle, `rcnt`=0, assert `out_start` and `out_valid`.
- R_DRAIN: `dout` = bank[`rd_bank`][`rcnt`].
  - On `out_valid` && `out_ready`, increment `rcnt`.
  - `out_valid` stays high until accepted. `dout` is stable while not accepted.
  - `out_last` = (`rcnt`==63).
- After the accepted transfer at `rcnt`=63: mark bank EMPTY, toggle `rd_bank`.
  - If the other bank is FULL, continue directly with `rcnt`=0. `out_start` stays high with no bubble.
  - Otherwise deassert `out_start` and `out_valid`, go to R_IDLE.

Latency and concurrency:
- Minimum latency: last input word to first `dout` = 2 cycles.
- Sustained throughput with `out_ready`=1: 1 word/cycle.
- A bank is never written and read in the same cycle.
- Freeing a bank and the first write to it in the same cycle is allowed: the EMPTY mark takes effect first.

Decomposition:
- Shared package `dct_pkg`:
  - constants NCOEF=64, CW=14, COEF_MSB=31, COEF_LSB=18
  - bank-state enum EMPTY/FULL
  - write/read FSM state encodings
- One sub-module, `coef_quant`: combinational round/shift/saturate of one coefficient, inputs c[13:0] and s[2:0], output v[13:0].
- Bank storage and both FSMs stay in the top.

Test Plan:
1. s=0; 64 words with `din[31:18]` = 0..63, `out_ready`=1 → `out_start` high for 64 cycles, `dout` = 0..63 sign-extended, `out_last` on word 63; first `dout` 2 cycles after the last input.
2. s=3; c = +13, -13, +4, -4, +3 → `dout` = 16, -16, 8, -8, 0.
3. s=7; c=8191 → 8191 (saturated); c=-8192 → -8192; c=-64 → -128 (half rounds away from zero).
4. Three back-to-back blocks with `out_ready`=0 → after two blocks `in_full`=1, the third block's words are dropped, `overflow`=1; then `out_ready`=1 → exactly 128 words out, blocks 1 then 2.
5. `out_ready` toggles 1,0,1,0 during a drain → each word held stable while not ready; 64 transfers in 128 cycles; words in order.
6. `reset` pulled low after 30 input words → all outputs 0 at once; after release, a fresh 64-word block drains correctly with no stale data.
